// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: memory request/response
// structs, the per-slot record and the queue defaults.
package fetch_queue_pkg;

  localparam int word_address_size         = 32;
  localparam int FETCH_QUEUE_DEPTH_DEFAULT = 4;
  localparam logic [3:0] WORD_READ_BYTES   = 4'b1111;

  typedef struct packed {
    logic                         valid;
    logic [word_address_size-1:0] addr;
    logic [31:0]                  data;
    logic [3:0]                   do_read;
    logic [3:0]                   do_write;
  } memory_io_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } memory_io_rsp;

  typedef struct packed {
    logic [word_address_size-1:0] pc;
    logic [31:0]                  instr;
    logic                         filled;
    logic                         live;
  } fetch_slot_t;

  localparam fetch_slot_t FETCH_SLOT_RESET = '0;

endpackage

// File: rtl/fetch_queue_ptr.sv
// Ring pointer with one extra wrap bit; reports its distance from a
// reference pointer so callers can derive occupancy and equality.
module fetch_queue_ptr #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_load,
  input  logic [PW-1:0] i_load_val,
  input  logic [PW-1:0] i_ref,
  output logic [PW-1:0] o_ptr,
  output logic [PW-1:0] o_dist
);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ptr <= '0;
    else if (i_load) r_ptr <= i_load_val;
    else if (i_inc)  r_ptr <= r_ptr + 1'b1;
  end

  // modulo 2*DEPTH subtraction: the wrap bit keeps full and empty distinct
  assign o_ptr  = r_ptr;
  assign o_dist = r_ptr - i_ref;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential word fetches, in-order fill, redirect
// kills queued and in-flight entries. FETCH_QUEUE_BYPASS_EN adds a
// same-cycle response-to-decode bypass.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FETCH_QUEUE_DEPTH_DEFAULT,
  parameter int ADDR_W = word_address_size
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] reset_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output memory_io_req      inst_mem_req,
  input  memory_io_rsp      inst_mem_rsp,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_OCC = PW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("fetch_queue: DEPTH must be a power of 2 and at least 2");
  end

  logic [PW-1:0]     w_alloc, w_fill, w_head;
  logic [PW-1:0]     w_occ, w_fill_gap, w_head_gap;
  logic [ADDR_W-1:0] r_pc, w_fetch_pc, w_req_pc;
  logic              r_pc_ok;
  fetch_slot_t       r_slots [DEPTH];
  fetch_slot_t       w_head_slot;
  logic              w_issue, w_rsp_acc, w_head_rdy, w_pop, w_discard, w_byp;

  fetch_queue_ptr #(.PW(PW)) u_alloc (
    .clk(clk), .rst_n(reset), .i_inc(w_issue), .i_load(1'b0), .i_load_val('0),
    .i_ref(w_head), .o_ptr(w_alloc), .o_dist(w_occ)
  );

  fetch_queue_ptr #(.PW(PW)) u_fill (
    .clk(clk), .rst_n(reset), .i_inc(w_rsp_acc), .i_load(1'b0), .i_load_val('0),
    .i_ref(w_alloc), .o_ptr(w_fill), .o_dist(w_fill_gap)
  );

  // redirect drops every ready entry by snapping head onto fill
  fetch_queue_ptr #(.PW(PW)) u_head (
    .clk(clk), .rst_n(reset), .i_inc(w_pop || w_discard), .i_load(redirect_valid),
    .i_load_val(w_fill), .i_ref(w_fill), .o_ptr(w_head), .o_dist(w_head_gap)
  );

  assign w_head_slot = r_slots[w_head[AW-1:0]];
  assign w_fetch_pc  = r_pc_ok ? r_pc : reset_pc;
  assign w_req_pc    = redirect_valid ? redirect_pc : w_fetch_pc;
  assign w_issue     = reset && (w_occ != FULL_OCC);
  assign w_rsp_acc   = inst_mem_rsp.valid && (w_fill_gap != '0);
  assign w_head_rdy  = (w_head_gap != '0);
  assign w_discard   = w_head_rdy && !w_head_slot.live;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = reset && !redirect_valid && !w_head_rdy && w_rsp_acc && w_head_slot.live;
`else
  assign w_byp = 1'b0;
`endif

  always_comb begin
    out_valid = w_head_rdy && w_head_slot.live && !redirect_valid;
    out_instr = w_head_slot.instr;
    out_pc    = w_head_slot.pc[ADDR_W-1:0];
    if (w_byp) begin
      out_valid = 1'b1;
      out_instr = inst_mem_rsp.data;
    end
  end

  assign w_pop = out_valid && out_ready;

  always_comb begin
    inst_mem_req = '0;
    if (w_issue) begin
      inst_mem_req.valid   = 1'b1;
      inst_mem_req.addr    = word_address_size'(w_req_pc);
      inst_mem_req.do_read = WORD_READ_BYTES;
    end
  end

  // a redirect blocked by a full queue still parks the fetch pc at its target
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= '0;
      r_pc_ok <= 1'b0;
    end else if (w_issue) begin
      r_pc    <= w_req_pc + ADDR_W'(4);
      r_pc_ok <= 1'b1;
    end else if (redirect_valid) begin
      r_pc    <= redirect_pc;
      r_pc_ok <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_slots[i] <= FETCH_SLOT_RESET;
    end else begin
      if (redirect_valid)
        for (int i = 0; i < DEPTH; i++) r_slots[i].live <= 1'b0;
      if (w_rsp_acc) begin
        r_slots[w_fill[AW-1:0]].instr  <= inst_mem_rsp.data;
        r_slots[w_fill[AW-1:0]].filled <= 1'b1;
      end
      // the new fetch stays live even when a redirect clears the rest
      if (w_issue) begin
        r_slots[w_alloc[AW-1:0]].pc     <= word_address_size'(w_req_pc);
        r_slots[w_alloc[AW-1:0]].instr  <= '0;
        r_slots[w_alloc[AW-1:0]].filled <= 1'b0;
        r_slots[w_alloc[AW-1:0]].live   <= 1'b1;
      end
    end
  end

  a_rsp_in_flight: assert property (@(posedge clk) disable iff (!reset)
    !(inst_mem_rsp.valid && (w_fill_gap == '0)))
    else $error("fetch_queue: response arrived with nothing in flight");

endmodule
